// File: rtl/regfile_master.sv
// rtl/regfile_master.sv - register-file bus initiator with burst command, write-data and read-response streams
module regfile_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Cmd_Valid,
  output logic                  Cmd_Ready,
  input  logic                  Cmd_Wr,
  input  logic [ADDR_WIDTH-1:0] Cmd_Addr,
  input  logic [ADDR_WIDTH-1:0] Cmd_Len,
  input  logic                  WData_Valid,
  input  logic [DATA_WIDTH-1:0] WData,
  output logic                  WData_Ready,
  output logic                  Rsp_Valid,
  output logic [DATA_WIDTH-1:0] Rsp_Data,
  output logic                  Rsp_Last,
  input  logic                  Rsp_Ready,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic                  Busy
);

  typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RESP} state_t;

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] startAddr;
  logic [ADDR_WIDTH-1:0] burstLen;
  logic [ADDR_WIDTH-1:0] beatCnt;
  logic [LAT_W-1:0]      latCnt;
  logic [ADDR_WIDTH-1:0] beatAddr;
  logic                  lastBeat;

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign beatAddr = startAddr + beatCnt;
  assign lastBeat = (beatCnt == burstLen);

  assign Cmd_Ready   = (state == IDLE);
  assign WData_Ready = (state == WRITE);
  assign Busy        = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      startAddr <= '0;
      burstLen  <= '0;
      beatCnt   <= '0;
      latCnt    <= '0;
      WrData    <= '0;
      Address   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Rsp_Valid <= 1'b0;
      Rsp_Data  <= '0;
      Rsp_Last  <= 1'b0;
    end else begin
      WrEn <= 1'b0;
      RdEn <= 1'b0;
      case (state)
        IDLE: begin
          if (Cmd_Valid) begin
            startAddr <= Cmd_Addr;
            burstLen  <= Cmd_Len;
            beatCnt   <= '0;
            if (Cmd_Wr) begin
              state <= WRITE;
            end else begin
              // RdEn is registered, so it is raised on entry to RD_REQ.
              state   <= RD_REQ;
              RdEn    <= 1'b1;
              Address <= Cmd_Addr;
            end
          end
        end
        WRITE: begin
          if (WData_Valid) begin
            WrEn    <= 1'b1;
            Address <= beatAddr;
            WrData  <= WData;
            if (lastBeat) state <= IDLE;
            else          beatCnt <= beatCnt + ADDR_WIDTH'(1);
          end
        end
        RD_REQ: begin
          latCnt <= '0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (latCnt == LAT_LAST) begin
            Rsp_Data  <= RdData;
            Rsp_Valid <= 1'b1;
            Rsp_Last  <= lastBeat;
            state     <= RESP;
          end else begin
            latCnt <= latCnt + LAT_W'(1);
          end
        end
        RESP: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            Rsp_Last  <= 1'b0;
            if (lastBeat) begin
              state <= IDLE;
            end else begin
              beatCnt <= beatCnt + ADDR_WIDTH'(1);
              Address <= beatAddr + ADDR_WIDTH'(1);
              RdEn    <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
// tb/tb_regfile_master.sv - self-checking bench for regfile_master with register-file model and scoreboards
module tb_regfile_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Cmd_Valid = 1'b0;
  logic        Cmd_Ready;
  logic        Cmd_Wr = 1'b0;
  logic [3:0]  Cmd_Addr = '0;
  logic [3:0]  Cmd_Len = '0;
  logic        WData_Valid = 1'b0;
  logic [15:0] WData = '0;
  logic        WData_Ready;
  logic        Rsp_Valid;
  logic [15:0] Rsp_Data;
  logic        Rsp_Last;
  logic        Rsp_Ready = 1'b1;
  logic [15:0] WrData;
  logic [3:0]  Address;
  logic        WrEn;
  logic        RdEn;
  logic [15:0] RdData;
  logic        Busy;

  always #5 CLK = ~CLK;

  regfile_master #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RD_LATENCY(1)) dut (
    .CLK(CLK), .RST(RST),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Wr(Cmd_Wr),
    .Cmd_Addr(Cmd_Addr), .Cmd_Len(Cmd_Len),
    .WData_Valid(WData_Valid), .WData(WData), .WData_Ready(WData_Ready),
    .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data), .Rsp_Last(Rsp_Last), .Rsp_Ready(Rsp_Ready),
    .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .RdData(RdData),
    .Busy(Busy)
  );

  // Register file with one cycle of read latency.
  logic [15:0] mem [16];
  logic [15:0] rdPipe;
  always @(posedge CLK) begin
    if (WrEn) mem[Address] <= WrData;
    if (RdEn) rdPipe <= mem[Address];
  end
  assign RdData = rdPipe;

  typedef struct { logic [3:0] addr; logic [15:0] data; } wexp_t;
  typedef struct { logic [15:0] data; logic last; } rexp_t;
  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [3:0]  len;
    logic [15:0] base;
    logic [15:0] step;
    int          gap;
  } vec_t;

  wexp_t wq[$];
  rexp_t rq[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares register-file traffic and responses against the scoreboards.
  int cyc = 0, rdCyc = 0, accCyc = 0;
  bit expectRd = 0, prevValid = 0, prevReady = 0, prevWHs = 0;
  logic [15:0] prevData = '0;
  logic prevLast = 1'b0;
  wexp_t we;
  rexp_t re;
  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      expectRd = 0; prevValid = 0; prevReady = 0; prevWHs = 0;
    end else begin
      if (WrEn && RdEn) check("wr_rd_exclusive", 32'(1), 32'(0));
      if (WrEn) begin
        check("wr_after_handshake", 32'(prevWHs), 32'(1));
        if (wq.size() == 0) check("wr_unexpected", 32'(1), 32'(0));
        else begin
          we = wq.pop_front();
          check("wr_addr", 32'(Address), 32'(we.addr));
          check("wr_data", 32'(WrData), 32'(we.data));
        end
      end
      if (RdEn) begin
        check("rd_while_pending", 32'(Rsp_Valid), 32'(0));
        if (expectRd) check("rd_after_accept", 32'(cyc - accCyc), 32'(1));
        expectRd = 0;
        rdCyc = cyc;
      end
      if (Rsp_Valid && !prevValid) check("rd_latency", 32'(cyc - rdCyc), 32'(2));
      if (Rsp_Valid && prevValid && !prevReady) begin
        check("hold_data", 32'(Rsp_Data), 32'(prevData));
        check("hold_last", 32'(Rsp_Last), 32'(prevLast));
      end
      if (Rsp_Valid && Rsp_Ready) begin
        if (rq.size() == 0) check("rsp_unexpected", 32'(1), 32'(0));
        else begin
          re = rq.pop_front();
          check("rsp_data", 32'(Rsp_Data), 32'(re.data));
          check("rsp_last", 32'(Rsp_Last), 32'(re.last));
        end
        if (!Rsp_Last) begin expectRd = 1; accCyc = cyc; end
      end
      prevValid = Rsp_Valid; prevReady = Rsp_Ready;
      prevData = Rsp_Data; prevLast = Rsp_Last;
      prevWHs = WData_Valid && WData_Ready;
    end
  end

  task automatic sendCmd(input bit wr, input logic [3:0] a, input logic [3:0] len);
    bit rdy = 0;
    int n = 0;
    Cmd_Valid = 1'b1; Cmd_Wr = wr; Cmd_Addr = a; Cmd_Len = len;
    while (!rdy && n < 100) begin
      @(negedge CLK); rdy = Cmd_Ready;
      @(posedge CLK); #1; n++;
    end
    Cmd_Valid = 1'b0;
    if (!rdy) check("cmd_timeout", 32'(0), 32'(1));
  endtask

  task automatic sendData(input logic [15:0] d, input logic [3:0] a, input int gap);
    bit rdy = 0;
    int n = 0;
    repeat (gap) begin
      @(posedge CLK); #1;
      check("busy_during_stall", 32'(Busy), 32'(1));
    end
    WData = d; WData_Valid = 1'b1;
    while (!rdy && n < 100) begin
      @(negedge CLK); rdy = WData_Ready;
      @(posedge CLK); #1; n++;
    end
    WData_Valid = 1'b0;
    if (!rdy) check("wdata_timeout", 32'(0), 32'(1));
    else wq.push_back('{addr: a, data: d});
  endtask

  task automatic waitIdle();
    int n = 0;
    bit done = 0;
    while (!done && n < 300) begin
      @(posedge CLK); #2; n++;
      done = !Busy && wq.size() == 0 && rq.size() == 0;
    end
    if (!done) check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic waitRsp();
    int n = 0;
    bit seen = 0;
    while (!seen && n < 50) begin
      @(posedge CLK); #2; n++;
      seen = Rsp_Valid;
    end
    if (!seen) check("rsp_timeout", 32'(0), 32'(1));
  endtask

  task automatic runRow(input vec_t v);
    sendCmd(v.wr, v.addr, v.len);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (v.wr) sendData(v.base + v.step * 16'(i), v.addr + 4'(i), (i == 0) ? 0 : v.gap);
      else rq.push_back('{data: v.base + v.step * 16'(i), last: (i == int'(v.len))});
    end
    waitIdle();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 4'd0,  4'd15, 16'h0100, 16'h0101, 0};
    vecs[1] = '{1'b0, 4'd0,  4'd15, 16'h0100, 16'h0101, 0};
    vecs[2] = '{1'b1, 4'd2,  4'd0,  16'hABCD, 16'h0000, 0};
    vecs[3] = '{1'b0, 4'd2,  4'd0,  16'hABCD, 16'h0000, 0};
    vecs[4] = '{1'b1, 4'd14, 4'd3,  16'h1111, 16'h1111, 0};
    vecs[5] = '{1'b0, 4'd14, 4'd3,  16'h1111, 16'h1111, 0};
    vecs[6] = '{1'b1, 4'd8,  4'd1,  16'hAAAA, 16'hAAAB, 2};
    vecs[7] = '{1'b0, 4'd8,  4'd1,  16'hAAAA, 16'hAAAB, 0};
    vecs[8] = '{1'b1, 4'd4,  4'd0,  16'h1234, 16'h0000, 0};
    vecs[9] = '{1'b0, 4'd4,  4'd0,  16'h1234, 16'h0000, 0};

    repeat (2) @(posedge CLK);
    #2;
    check("rst_in_cmd_ready", 32'(Cmd_Ready), 32'(1));
    check("rst_in_busy", 32'(Busy), 32'(0));
    RST = 1'b1;
    @(posedge CLK); #2;
    check("rst_outputs", 32'({WrData, Address, WrEn, RdEn, Rsp_Valid, Rsp_Last, WData_Ready, Busy}), 32'(0));
    check("rst_rsp_data", 32'(Rsp_Data), 32'(0));
    check("rst_cmd_ready", 32'(Cmd_Ready), 32'(1));

    for (int r = 0; r < 8; r++) runRow(vecs[r]);

    // Response backpressure in the middle of a wrapping read burst.
    Rsp_Ready = 1'b0;
    sendCmd(1'b0, 4'd14, 4'd3);
    for (int i = 0; i < 4; i++) rq.push_back('{data: 16'h1111 * 16'(i + 1), last: (i == 3)});
    waitRsp();
    Rsp_Ready = 1'b1;
    @(posedge CLK); #1;
    Rsp_Ready = 1'b0;
    waitRsp();
    repeat (5) begin
      @(posedge CLK); #2;
      check("bp_valid_held", 32'(Rsp_Valid), 32'(1));
      check("bp_no_rden", 32'(RdEn), 32'(0));
    end
    Rsp_Ready = 1'b1;
    waitIdle();

    // Reset while the second beat of a four-beat write is being issued.
    sendCmd(1'b1, 4'd0, 4'd3);
    sendData(16'hDEAD, 4'd0, 0);
    sendData(16'hBEEF, 4'd1, 0);
    #1 RST = 1'b0;
    #1;
    check("mid_rst_wren", 32'(WrEn), 32'(0));
    check("mid_rst_busy", 32'(Busy), 32'(0));
    check("mid_rst_cmd_ready", 32'(Cmd_Ready), 32'(1));
    check("mid_rst_wdata_ready", 32'(WData_Ready), 32'(0));
    wq.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #2;
    check("post_rst_cmd_ready", 32'(Cmd_Ready), 32'(1));
    runRow(vecs[8]);
    runRow(vecs[9]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
